// File: rtl/race_referee_pkg.sv
// rtl/race_referee_pkg.sv - shared game state codes, winner codes and checkpoint geometry
package race_referee_pkg;

  typedef enum logic [2:0] {
    GS_IDLE      = 3'd0,
    GS_SETTING   = 3'd1,
    GS_COUNTDOWN = 3'd3,
    GS_RACING    = 3'd4,
    GS_PAUSE     = 3'd5,
    GS_FINISH    = 3'd6
  } game_state_e;

  typedef enum logic [2:0] {
    REF_CLEAR,
    REF_ARMED,
    REF_RUN,
    REF_HOLD,
    REF_DONE
  } ref_state_e;

  localparam logic [1:0]  WIN_NONE = 2'd0;
  localparam logic [1:0]  WIN_P1   = 2'd1;
  localparam logic [1:0]  WIN_P2   = 2'd2;
  localparam logic [1:0]  WIN_TIE  = 2'd3;
  localparam logic [13:0] TIME_MAX = 14'd9999;

  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] x1;
    logic [9:0] y0;
    logic [9:0] y1;
  } cp_rect_t;

  // CP0 is the start/finish line along the bottom edge of the map
  function automatic cp_rect_t cp_rect(input logic [1:0] idx);
    cp_rect_t r;
    case (idx)
      2'd0:    r = '{x0: 10'd150, x1: 10'd169, y0: 10'd200, y1: 10'd239};
      2'd1:    r = '{x0: 10'd280, x1: 10'd319, y0: 10'd100, y1: 10'd139};
      2'd2:    r = '{x0: 10'd150, x1: 10'd169, y0: 10'd0,   y1: 10'd39};
      default: r = '{x0: 10'd0,   x1: 10'd39,  y0: 10'd100, y1: 10'd139};
    endcase
    return r;
  endfunction

  function automatic logic in_rect(input cp_rect_t r, input logic [9:0] x, input logic [9:0] y);
    return (x >= r.x0) && (x <= r.x1) && (y >= r.y0) && (y <= r.y1);
  endfunction

endpackage

// File: rtl/race_referee_cp_tracker.sv
// rtl/race_referee_cp_tracker.sv - per-player checkpoint/lap tracker with entry-edge detection
module race_referee_cp_tracker
  import race_referee_pkg::*;
#(
  parameter int NUM_CP      = 4,
  parameter int LAPS_TO_WIN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [1:0] next_cp,
  output logic [1:0] lap,
  output logic       done
);

  logic [1:0] next_cp_q, next_cp_d;
  logic [1:0] lap_q, lap_d;
  logic       done_q, done_d;
  logic       prev_in_box_q, prev_in_box_d;
  logic       in_box;
  logic       entry;

  always_comb begin
    in_box        = in_rect(cp_rect(next_cp_q), x, y);
    entry         = in_box && !prev_in_box_q;
    next_cp_d     = next_cp_q;
    lap_d         = lap_q;
    done_d        = done_q;
    // Edge history tracks the box even while counting is disabled, so a resume inside a box is not an entry
    prev_in_box_d = clr ? 1'b0 : in_box;
    if (clr) begin
      next_cp_d = 2'd1;
      lap_d     = 2'd0;
      done_d    = 1'b0;
    end else if (en && entry) begin
      if (next_cp_q == 2'd0) begin
        next_cp_d = 2'd1;
        if (lap_q != 2'(LAPS_TO_WIN)) begin
          lap_d = lap_q + 2'd1;
        end
        if (({1'b0, lap_q} + 3'd1) >= 3'(LAPS_TO_WIN)) begin
          done_d = 1'b1;
        end
      end else if (next_cp_q == 2'(NUM_CP - 1)) begin
        next_cp_d = 2'd0;
      end else begin
        next_cp_d = next_cp_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      next_cp_q     <= 2'd1;
      lap_q         <= 2'd0;
      done_q        <= 1'b0;
      prev_in_box_q <= 1'b0;
    end else begin
      next_cp_q     <= next_cp_d;
      lap_q         <= lap_d;
      done_q        <= done_d;
      prev_in_box_q <= prev_in_box_d;
    end
  end

  assign next_cp = next_cp_q;
  assign lap     = lap_q;
  assign done    = done_q;

endmodule

// File: rtl/race_referee.sv
// rtl/race_referee.sv - race referee: position registers, referee FSM, race timer and winner latch
module race_referee
  import race_referee_pkg::*;
#(
  parameter int NUM_CP      = 4,
  parameter int LAPS_TO_WIN = 3,
  parameter int TICK_CYCLES = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  state,
  input  logic [9:0]  p1_x,
  input  logic [9:0]  p1_y,
  input  logic [9:0]  p2_x,
  input  logic [9:0]  p2_y,
  output logic [1:0]  p1_flag_order,
  output logic [1:0]  p2_flag_order,
  output logic [1:0]  p1_lap,
  output logic [1:0]  p2_lap,
  output logic [13:0] race_time,
  output logic [1:0]  winner,
  output logic        is_game_end
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [9:0]  p1_x_q, p1_y_q, p2_x_q, p2_y_q;
  ref_state_e  fsm_q, fsm_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [13:0] time_q, time_d;
  logic [1:0]  winner_q, winner_d;
  logic        game_end_q, game_end_d;
  logic        p1_done, p2_done, any_done;
  logic        run_en, trk_clr;

  assign any_done = p1_done || p2_done;
  // Counting stops on the edge a player finishes, one cycle before DONE is entered
  assign run_en   = (fsm_q == REF_RUN) && !any_done;
  assign trk_clr  = (fsm_q == REF_CLEAR);

  race_referee_cp_tracker #(.NUM_CP(NUM_CP), .LAPS_TO_WIN(LAPS_TO_WIN)) u_trk_p1 (
    .clk     (clk),
    .rst     (rst),
    .en      (run_en),
    .clr     (trk_clr),
    .x       (p1_x_q),
    .y       (p1_y_q),
    .next_cp (p1_flag_order),
    .lap     (p1_lap),
    .done    (p1_done)
  );

  race_referee_cp_tracker #(.NUM_CP(NUM_CP), .LAPS_TO_WIN(LAPS_TO_WIN)) u_trk_p2 (
    .clk     (clk),
    .rst     (rst),
    .en      (run_en),
    .clr     (trk_clr),
    .x       (p2_x_q),
    .y       (p2_y_q),
    .next_cp (p2_flag_order),
    .lap     (p2_lap),
    .done    (p2_done)
  );

  always_comb begin
    fsm_d = fsm_q;
    if (fsm_q == REF_DONE) begin
      if (state == GS_IDLE) fsm_d = REF_CLEAR;
    end else if (any_done) begin
      fsm_d = REF_DONE;
    end else begin
      case (game_state_e'(state))
        GS_IDLE, GS_SETTING: fsm_d = REF_CLEAR;
        GS_COUNTDOWN:        fsm_d = REF_ARMED;
        GS_RACING:           fsm_d = REF_RUN;
        default:             fsm_d = REF_HOLD;
      endcase
    end

    // Done flags map directly onto the winner code, including the simultaneous-finish tie
    winner_d = winner_q;
    if (fsm_d == REF_CLEAR) begin
      winner_d = WIN_NONE;
    end else if ((fsm_d == REF_DONE) && (fsm_q != REF_DONE)) begin
      winner_d = {p2_done, p1_done};
    end
    game_end_d = (fsm_d == REF_DONE);

    presc_d = presc_q;
    time_d  = time_q;
    if (fsm_q == REF_CLEAR) begin
      presc_d = '0;
      time_d  = 14'd0;
    end else if (run_en) begin
      if (presc_q == PW'(TICK_CYCLES - 1)) begin
        presc_d = '0;
        if (time_q != TIME_MAX) time_d = time_q + 14'd1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_x_q     <= 10'd0;
      p1_y_q     <= 10'd0;
      p2_x_q     <= 10'd0;
      p2_y_q     <= 10'd0;
      fsm_q      <= REF_CLEAR;
      presc_q    <= '0;
      time_q     <= 14'd0;
      winner_q   <= WIN_NONE;
      game_end_q <= 1'b0;
    end else begin
      p1_x_q     <= p1_x;
      p1_y_q     <= p1_y;
      p2_x_q     <= p2_x;
      p2_y_q     <= p2_y;
      fsm_q      <= fsm_d;
      presc_q    <= presc_d;
      time_q     <= time_d;
      winner_q   <= winner_d;
      game_end_q <= game_end_d;
    end
  end

  assign race_time   = time_q;
  assign winner      = winner_q;
  assign is_game_end = game_end_q;

endmodule
